fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: PC register, next-PC selection and the IF/ID pipeline register.
- Sits directly upstream of the load-use hazard detection logic.
- Consumes its PC_Write / IF_ID_write stall outputs and the EX/MEM branch redirect.
- Drives the instruction-memory address and produces the IF/ID fields read by decode.
- Also keeps saturating stall/flush event counters for pipeline debug.

Parameters:
ADDR_W, 64, PC / address width in bits
INST_W, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset (bits [1:0] must be 0)
CNT_W, 32, width of stall and flush event counters

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
PC_Write  input  1  1 = PC may advance; 0 = hold PC (load-use stall)
IF_ID_write  input  1  1 = IF/ID register loads; 0 = hold contents
branch_taken  input  1  redirect request from EX/MEM (resolved branch/jump)
branch_target  input  ADDR_W  redirect PC, valid when branch_taken=1
imem_addr  output  ADDR_W  instruction-memory address; equals the PC register
imem_rdata  input  INST_W  instruction word; combinational read of imem_addr, same cycle
IF_ID_PC  output  ADDR_W  PC of the instruction held in IF/ID
IF_ID_Instr  output  INST_W  instruction held in IF/ID
IF_ID_valid  output  1  1 = IF/ID holds a real fetched instruction
stall_count  output  CNT_W  cycles in which a stall held the PC
flush_count  output  CNT_W  number of IF/ID flushes performed

Behaviour:
- Reset (reset=1 at a rising edge; overrides every other input):
  - PC = RESET_PC; IF_ID_PC = 0; IF_ID_Instr = NOP (0x00000013); IF_ID_valid = 0.
  - stall_count = 0; flush_count = 0.
  - Reset asserted mid-stall or mid-redirect discards that operation completely.
- Start-up FSM, states BOOT and RUN:
  - Reset enters BOOT.
  - BOOT lasts exactly one cycle: PC does not advance; IF/ID stays NOP with valid=0; counters do not count. This gives the imem one settle cycle.
  - BOOT always moves to RUN, ignoring all inputs. RUN persists until reset.
- Next PC in RUN, evaluated in this priority order:
  1. branch_taken=1: PC <= {branch_target[ADDR_W-1:2], 2'b00}. This applies regardless of PC_Write.
  2. else PC_Write=1: PC <= PC + 4, modulo 2^ADDR_W (all-ones-minus-3 wraps to 0).
  3. else PC holds.
- IF/ID register in RUN:
  - branch_taken=1: flush. IF_ID_Instr <= NOP, IF_ID_valid <= 0, IF_ID_PC <= 0. The flush wins over IF_ID_write=0.
  - else IF_ID_write=1: IF_ID_PC <= PC, IF_ID_Instr <= imem_rdata, IF_ID_valid <= 1.
  - else all three fields hold.
- PC_Write and IF_ID_write are independent. The block never forces them to agree. PC_Write=0 with IF_ID_write=1 re-latches the same PC/instruction each cycle.
- Latency:
  - Instruction at address A appears on IF_ID_Instr one cycle after PC==A with IF_ID_write=1.
  - A redirect raised in cycle N makes the target visible on imem_addr in cycle N+1 and in IF/ID in cycle N+2.
- Counters (RUN only), saturating at all-ones with no wrap:
  - stall_count +1 in each cycle with PC_Write=0 and branch_taken=0.
  - flush_count +1 in each cycle with branch_taken=1.
- imem_addr is a direct combinational copy of the PC register, with no extra register stage.

Decomposition:
- Shared definitions file riscv_defs: NOP_INSTR = 32'h00000013, PC_STEP = 4, FSM state encodings BOOT/RUN, default RESET_PC.
- One natural sub-module, if_id_register: IF/ID fields plus the flush/write-enable priority.
- PC, next-PC logic, FSM and counters live in fetch_stage.

Test Plan:
1. Reset, then release; run 4 cycles with PC_Write=IF_ID_write=1, imem returning 0x100+addr -> cycle1 BOOT (PC=0, valid=0); then imem_addr 0,4,8; IF_ID_PC 0,4 with valid=1; IF_ID_Instr 0x100, 0x104.
2. Hold PC_Write=IF_ID_write=0 for 2 cycles at PC=8 -> PC stays 8; IF/ID unchanged; stall_count +2; then resume -> PC=12 next cycle.
3. branch_taken=1, branch_target=0x203 while PC_Write=0 -> next PC=0x200; IF_ID_Instr=NOP, valid=0; flush_count +1; stall_count unchanged; one cycle later IF_ID_PC=0x200.
4. Set PC to 2^64-4 via redirect, then advance one cycle -> PC wraps to 0.
5. Preload stall_count to all-ones (force/long run), then stall 1 more cycle -> stays all-ones.
6. Assert reset during a stall with branch_taken=1 -> PC=RESET_PC, valid=0, both counters 0, BOOT re-entered.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0) used for bubbles
//   PC_STEP          : sequential PC increment in bytes
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   fetch_state_e    : start-up FSM states (BOOT, RUN)
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          PC_STEP          = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // BOOT: one settle cycle for the instruction memory after reset.
  // RUN : normal fetching until the next reset.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundle of the fetch-stage control, memory and IF/ID signals.
//   master modport : the fetch stage itself
//   slave  modport : the surrounding pipeline / hazard unit / imem
// Signals:
//   PC_Write, IF_ID_write : stall enables from the hazard unit
//   branch_taken/target   : EX/MEM redirect
//   imem_addr/imem_rdata  : combinational instruction memory port
//   IF_ID_PC/Instr/valid  : IF/ID register contents for decode
//   stall_count/flush_count : saturating debug event counters
//   dbg_state             : current start-up FSM state
//
// Flow control: there is no valid/ready pair. PC_Write and IF_ID_write are
// level enables sampled on every rising edge; deasserting one holds the
// corresponding register for that cycle. branch_taken is a single-cycle
// request that is acted on at the same edge it is seen high.
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
);

  logic                          PC_Write;
  logic                          IF_ID_write;
  logic                          branch_taken;
  logic [ADDR_W-1:0]             branch_target;
  logic [ADDR_W-1:0]             imem_addr;
  logic [INST_W-1:0]             imem_rdata;
  logic [ADDR_W-1:0]             IF_ID_PC;
  logic [INST_W-1:0]             IF_ID_Instr;
  logic                          IF_ID_valid;
  logic [CNT_W-1:0]              stall_count;
  logic [CNT_W-1:0]              flush_count;
  fetch_stage_pkg::fetch_state_e dbg_state;

  modport master (
    input  PC_Write,
    input  IF_ID_write,
    input  branch_taken,
    input  branch_target,
    input  imem_rdata,
    output imem_addr,
    output IF_ID_PC,
    output IF_ID_Instr,
    output IF_ID_valid,
    output stall_count,
    output flush_count,
    output dbg_state
  );

  modport slave (
    output PC_Write,
    output IF_ID_write,
    output branch_taken,
    output branch_target,
    output imem_rdata,
    input  imem_addr,
    input  IF_ID_PC,
    input  IF_ID_Instr,
    input  IF_ID_valid,
    input  stall_count,
    input  flush_count,
    input  dbg_state
  );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// ---------------------------------------------------------------------------
// fetch_stage_if_id_register
// IF/ID pipeline register with flush-over-write priority.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_flush    : squash contents to a NOP bubble (wins over i_write)
//   i_write    : load i_pc / i_instr as a valid instruction
//   i_pc       : PC of the instruction being fetched this cycle
//   i_instr    : instruction word from the instruction memory
//   o_pc, o_instr, o_valid : registered IF/ID fields
// Both enables are expected to be gated to zero while the stage boots.
// ---------------------------------------------------------------------------
module fetch_stage_if_id_register
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_instr,
  output logic              o_valid
);

  localparam logic [INST_W-1:0] BUBBLE = INST_W'(NOP_INSTR);

  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_instr;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_instr <= BUBBLE;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      // A redirect kills the wrong-path instruction even while decode stalls.
      r_pc    <= '0;
      r_instr <= BUBBLE;
      r_valid <= 1'b0;
    end else if (i_write) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: PC register, next-PC selection, start-up FSM,
// IF/ID register and saturating stall/flush debug counters.
// Ports:
//   clk   : pipeline clock, all state updates on the rising edge
//   reset : synchronous active-high reset, overrides all other inputs
//   bus   : fetch_stage_if.master (stall enables, redirect, imem port,
//           IF/ID outputs, counters, FSM state)
// imem_addr is the PC register itself; the instruction memory answers
// combinationally within the same cycle.
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(3);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              w_run;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_tgt_aligned;

  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_stall_ev;
  logic              w_flush_ev;

  logic              w_ifid_flush;
  logic              w_ifid_write;

  // ---------------- start-up FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // Single settle cycle; inputs are ignored here.
        w_state_nxt = ST_RUN;
        w_run       = 1'b0;
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_run       = 1'b1;
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_run       = 1'b0;
      end
    endcase
  end

  // ---------------- next-PC selection ----------------
  // Masking (rather than slicing) keeps every target bit in the expression.
  assign w_tgt_aligned = bus.branch_target & ~LOW_MASK;

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_run) begin
      if (bus.branch_taken) begin
        // Redirect wins over a load-use stall: the stalled instruction is
        // on the wrong path anyway.
        w_pc_nxt = w_tgt_aligned;
      end else if (bus.PC_Write) begin
        w_pc_nxt = r_pc + STEP;  // wraps modulo 2^ADDR_W
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_pc_nxt;
  end

  // ---------------- debug event counters ----------------
  assign w_stall_ev = w_run & ~bus.PC_Write & ~bus.branch_taken;
  assign w_flush_ev = w_run & bus.branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      // Saturate at all-ones so a long debug run never reads back as small.
      if (w_stall_ev && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_ev && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // ---------------- IF/ID register ----------------
  assign w_ifid_flush = w_run & bus.branch_taken;
  assign w_ifid_write = w_run & bus.IF_ID_write;

  fetch_stage_if_id_register #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_ifid_flush),
    .i_write (w_ifid_write),
    .i_pc    (r_pc),
    .i_instr (bus.imem_rdata),
    .o_pc    (bus.IF_ID_PC),
    .o_instr (bus.IF_ID_Instr),
    .o_valid (bus.IF_ID_valid)
  );

  // ---------------- outputs ----------------
  assign bus.imem_addr   = r_pc;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural model tracks the
// architectural state from the stage's rules; a negedge compare process
// checks every output each cycle, and directed steps pin literal values.
// Counters are built narrow (CNT_W=4) so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

  fetch_stage #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .RESET_PC (64'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: word at address A is 0x100 + A (low 32 bits).
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return 32'h100 + a[31:0];
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  // ---------------- bookkeeping ----------------
  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_pc;
  logic [63:0] m_ifid_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  int          m_stall;
  int          m_flush;
  bit          m_boot;
  logic [INST_W-1:0] exp_q[$];

  task automatic model_step(input bit rst, input bit pcw, input bit ifw,
                            input bit br, input logic [63:0] tgt);
    logic [63:0] old_pc;
    old_pc = m_pc;
    if (rst) begin
      m_pc = 64'h0; m_ifid_pc = 64'h0; m_instr = NOP_INSTR; m_valid = 0;
      m_stall = 0; m_flush = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else begin
      if (br)       m_pc = (tgt / 4) * 4;
      else if (pcw) m_pc = old_pc + 64'd4;
      if (br) begin
        m_ifid_pc = 64'h0; m_instr = NOP_INSTR; m_valid = 0;
      end else if (ifw) begin
        m_ifid_pc = old_pc; m_instr = imem_word(old_pc); m_valid = 1;
      end
      if (!pcw && !br && m_stall < CNT_MAX) m_stall++;
      if (br && m_flush < CNT_MAX) m_flush++;
    end
    if (chk_en) exp_q.push_back(m_instr);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr",   bus.imem_addr,   m_pc);
      chk("IF_ID_PC",    bus.IF_ID_PC,    m_ifid_pc);
      chk("IF_ID_valid", 64'(bus.IF_ID_valid), 64'(m_valid));
      chk("stall_count", 64'(bus.stall_count), 64'(m_stall));
      chk("flush_count", 64'(bus.flush_count), 64'(m_flush));
      chk("dbg_state",   64'(bus.dbg_state),   m_boot ? 64'(ST_BOOT) : 64'(ST_RUN));
      if (exp_q.size() == 0) begin
        chk("IF_ID_Instr_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("IF_ID_Instr", 64'(bus.IF_ID_Instr), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit rst, input bit pcw, input bit ifw,
                       input bit br, input logic [63:0] tgt);
    reset             = rst;
    bus.PC_Write      = pcw;
    bus.IF_ID_write   = ifw;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    @(posedge clk);
    model_step(rst, pcw, ifw, br, tgt);
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.PC_Write = 0; bus.IF_ID_write = 0; bus.branch_taken = 0; bus.branch_target = '0;

    // Reset and boot
    cycle(1, 1, 1, 0, 64'h0);
    chk_en = 1'b1;
    cycle(1, 1, 1, 0, 64'h0);
    chk("rst_pc",    bus.imem_addr, 64'h0);
    chk("rst_valid", 64'(bus.IF_ID_valid), 64'h0);
    chk("rst_instr", 64'(bus.IF_ID_Instr), 64'h13);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_BOOT));
    cycle(0, 1, 1, 0, 64'h0);                   // BOOT cycle
    chk("boot_pc",    bus.imem_addr, 64'h0);
    chk("boot_valid", 64'(bus.IF_ID_valid), 64'h0);
    chk("boot_cnt",   64'(bus.stall_count), 64'h0);
    cycle(0, 1, 1, 0, 64'h0);
    chk("run1_pc",    bus.imem_addr, 64'h4);
    chk("run1_ifpc",  bus.IF_ID_PC,  64'h0);
    chk("run1_instr", 64'(bus.IF_ID_Instr), 64'h100);
    cycle(0, 1, 1, 0, 64'h0);
    chk("run2_pc",    bus.imem_addr, 64'h8);
    chk("run2_ifpc",  bus.IF_ID_PC,  64'h4);
    chk("run2_instr", 64'(bus.IF_ID_Instr), 64'h104);

    // Stall two cycles at PC=8, then resume
    cycle(0, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 64'h0);
    chk("stall_pc",    bus.imem_addr, 64'h8);
    chk("stall_ifpc",  bus.IF_ID_PC,  64'h4);
    chk("stall_count", 64'(bus.stall_count), 64'h2);
    cycle(0, 1, 1, 0, 64'h0);
    chk("resume_pc",   bus.imem_addr, 64'hC);
    chk("resume_ifpc", bus.IF_ID_PC,  64'h8);

    // Redirect during a stall
    cycle(0, 0, 1, 1, 64'h203);
    chk("br_pc",    bus.imem_addr, 64'h200);
    chk("br_instr", 64'(bus.IF_ID_Instr), 64'h13);
    chk("br_valid", 64'(bus.IF_ID_valid), 64'h0);
    chk("br_flush", 64'(bus.flush_count), 64'h1);
    chk("br_stall", 64'(bus.stall_count), 64'h2);
    cycle(0, 1, 1, 0, 64'h0);
    chk("br2_ifpc",  bus.IF_ID_PC, 64'h200);
    chk("br2_instr", 64'(bus.IF_ID_Instr), 64'h300);

    // PC wrap at the top of the address space
    cycle(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("top_pc", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(0, 1, 1, 0, 64'h0);
    chk("wrap_pc",    bus.imem_addr, 64'h0);
    chk("wrap_instr", 64'(bus.IF_ID_Instr), 64'hFC);

    // Stall counter saturation
    repeat (15) cycle(0, 0, 1, 0, 64'h0);
    chk("sat_stall", 64'(bus.stall_count), 64'hF);
    cycle(0, 0, 0, 0, 64'h0);
    chk("sat_hold", 64'(bus.stall_count), 64'hF);

    // Randomized traffic, occasional reset, some targets near the top
    for (int i = 0; i < 400; i++) begin
      logic [63:0] tgt;
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0,
            tgt);
    end

    // Reset during a stall with a redirect pending
    cycle(0, 0, 0, 0, 64'h0);
    cycle(1, 0, 0, 1, 64'h400);
    chk("rst2_pc",    bus.imem_addr, 64'h0);
    chk("rst2_valid", 64'(bus.IF_ID_valid), 64'h0);
    chk("rst2_stall", 64'(bus.stall_count), 64'h0);
    chk("rst2_flush", 64'(bus.flush_count), 64'h0);
    chk("rst2_state", 64'(bus.dbg_state), 64'(ST_BOOT));
    cycle(0, 1, 1, 1, 64'h800);                 // ignored in BOOT
    chk("rst2_boot_pc",    bus.imem_addr, 64'h0);
    chk("rst2_boot_flush", 64'(bus.flush_count), 64'h0);
    chk("rst2_run_state",  64'(bus.dbg_state), 64'(ST_RUN));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
